ps2_scan_receiver: RTL and testbench

//  Receives the PS/2 keyboard serial stream (ps2_clk/ps2_data, device-driven) and

---
 rtl/ps2_pkg.sv | 17 +
 rtl/ps2_line_filter.sv | 61 ++++++
 rtl/ps2_scan_receiver.sv | 148 ++++++++++++++
 tb/tb_ps2_scan_receiver.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 scan-code receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_CODE_EXT   = 8'hE0;
  localparam logic [7:0] PS2_CODE_BREAK = 8'hF0;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_LEN = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the raw PS/2 lines, deglitches ps2_clk and emits a one-cycle
// pulse on each filtered falling edge. SYNC_STAGES must be at least 2.
module ps2_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_s,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic [CW-1:0]          flt_cnt_q, flt_cnt_d;
  logic                   flt_q, flt_d;
  logic                   fall_q, fall_d;
  logic                   clk_s;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = fall_q;

  // The filtered level flips only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    flt_d       = flt_q;
    flt_cnt_d   = '0;
    fall_d      = 1'b0;
    if (clk_s != flt_q) begin
      if (flt_cnt_q == CW'(FILTER_LEN - 1)) begin
        flt_d  = clk_s;
        fall_d = flt_q;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      flt_cnt_q   <= '0;
      flt_q       <= 1'b1;
      fall_q      <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      flt_cnt_q   <= flt_cnt_d;
      flt_q       <= flt_d;
      fall_q      <= fall_d;
    end
  end

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: frames bytes, drops break sequences, tracks the E0
// prefix and strobes each accepted make code out on Cambio/got_data.
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] Cambio,
  output logic       got_data,
  output logic       ext_key,
  output logic       frame_err
);

  localparam int DATA_BITS = PS2_FRAME_LEN - 3;
  localparam int TW        = $clog2(TIMEOUT_CYC + 1);

  logic data_s;
  logic fall;

  ps2_state_t    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    cambio_q, cambio_d;
  logic          got_data_q, got_data_d;
  logic          ext_key_q, ext_key_d;
  logic          frame_err_q, frame_err_d;
  logic          ext_pend_q, ext_pend_d;
  logic          brk_pend_q, brk_pend_d;

  ps2_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_line_filter (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .data_s   (data_s),
    .fall     (fall)
  );

  assign Cambio    = cambio_q;
  assign got_data  = got_data_q;
  assign ext_key   = ext_key_q;
  assign frame_err = frame_err_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    tmo_d       = '0;
    cambio_d    = cambio_q;
    ext_key_d   = ext_key_q;
    got_data_d  = 1'b0;
    frame_err_d = 1'b0;
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;

    // A stalled partial frame is abandoned without touching the prefix flags.
    if (state_q != IDLE && !fall) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        frame_err_d = 1'b1;
        state_d     = IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    if (fall) begin
      case (state_q)
        IDLE: begin
          if (!data_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (data_s && (^{shift_q, par_q})) begin
            if (shift_q == PS2_CODE_EXT) begin
              ext_pend_d = 1'b1;
            end else if (shift_q == PS2_CODE_BREAK) begin
              brk_pend_d = 1'b1;
            end else if (brk_pend_q) begin
              brk_pend_d = 1'b0;
              ext_pend_d = 1'b0;
            end else begin
              cambio_d   = shift_q;
              ext_key_d  = ext_pend_q;
              got_data_d = 1'b1;
              ext_pend_d = 1'b0;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      cambio_q    <= 8'h00;
      got_data_q  <= 1'b0;
      ext_key_q   <= 1'b0;
      frame_err_q <= 1'b0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      cambio_q    <= cambio_d;
      got_data_q  <= got_data_d;
      ext_key_q   <= ext_key_d;
      frame_err_q <= frame_err_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
    end
  end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver: hand-built PS/2 frames with known results.
module tb_ps2_scan_receiver;

  localparam int HALF = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] Cambio;
  logic       got_data;
  logic       ext_key;
  logic       frame_err;

  int checkCount = 0;
  int passCount = 0;
  int gdCount = 0;
  int errCount = 0;
  int overlapCount = 0;
  int backToBack = 0;
  logic gdPrev = 1'b0;
  int gdBase;
  int errBase;

  always #5 clk = ~clk;

  ps2_scan_receiver dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .Cambio    (Cambio),
    .got_data  (got_data),
    .ext_key   (ext_key),
    .frame_err (frame_err)
  );

  // Pulse bookkeeping, sampled on the inactive edge.
  always @(negedge clk) begin
    if (got_data) gdCount <= gdCount + 1;
    if (frame_err) errCount <= errCount + 1;
    if (got_data && frame_err) overlapCount <= overlapCount + 1;
    if (got_data && gdPrev) backToBack <= backToBack + 1;
    gdPrev <= got_data;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit: data set while clock high, then a full low phase.
  task automatic sendBit(input logic b, input bit glitch);
    ps2_data = b;
    waitCycles(HALF / 2);
    ps2_clk = 1'b0;
    waitCycles(HALF);
    ps2_clk = 1'b1;
    if (glitch) begin
      waitCycles(5);
      ps2_clk = 1'b0;
      waitCycles(3);
      ps2_clk = 1'b1;
    end
    waitCycles(HALF / 2);
  endtask

  task automatic applyStimulus(input logic [7:0] code, input bit parBad,
                               input bit stopBad, input bit glitch);
    logic parity;
    parity = (~^code) ^ parBad;
    sendBit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) sendBit(code[i], glitch && (i == 3));
    sendBit(parity, 1'b0);
    sendBit(!stopBad, 1'b0);
    waitCycles(20);
  endtask

  task automatic markCounts();
    gdBase  = gdCount;
    errBase = errCount;
  endtask

  initial begin
    waitCycles(5);
    checkOutput("rst_cambio", {24'd0, Cambio}, 32'h00);
    checkOutput("rst_gd", {31'd0, got_data}, 32'd0);
    checkOutput("rst_ext", {31'd0, ext_key}, 32'd0);
    checkOutput("rst_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b1;
    waitCycles(20);

    markCounts();
    applyStimulus(8'h7A, 0, 0, 0);
    checkOutput("7a_gd", gdCount - gdBase, 1);
    checkOutput("7a_err", errCount - errBase, 0);
    checkOutput("7a_cambio", {24'd0, Cambio}, 32'h7A);
    checkOutput("7a_ext", {31'd0, ext_key}, 32'd0);

    markCounts();
    applyStimulus(8'h69, 0, 0, 0);
    checkOutput("69_gd", gdCount - gdBase, 1);
    applyStimulus(8'hF0, 0, 0, 0);
    applyStimulus(8'h69, 0, 0, 0);
    checkOutput("brk_gd", gdCount - gdBase, 1);
    checkOutput("brk_cambio", {24'd0, Cambio}, 32'h69);

    markCounts();
    applyStimulus(8'hE0, 0, 0, 0);
    applyStimulus(8'h7A, 0, 0, 0);
    checkOutput("e0_gd", gdCount - gdBase, 1);
    checkOutput("e0_cambio", {24'd0, Cambio}, 32'h7A);
    checkOutput("e0_ext", {31'd0, ext_key}, 32'd1);

    markCounts();
    applyStimulus(8'h7A, 0, 0, 0);
    checkOutput("plain_gd", gdCount - gdBase, 1);
    checkOutput("plain_cambio", {24'd0, Cambio}, 32'h7A);
    checkOutput("plain_ext", {31'd0, ext_key}, 32'd0);

    markCounts();
    applyStimulus(8'h7A, 1, 0, 0);
    checkOutput("par_err", errCount - errBase, 1);
    checkOutput("par_gd", gdCount - gdBase, 0);
    checkOutput("par_cambio", {24'd0, Cambio}, 32'h7A);

    markCounts();
    applyStimulus(8'h7A, 0, 1, 0);
    checkOutput("stop_err", errCount - errBase, 1);
    checkOutput("stop_gd", gdCount - gdBase, 0);
    checkOutput("stop_cambio", {24'd0, Cambio}, 32'h7A);

    markCounts();
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    sendBit(1'b0, 1'b0);
    waitCycles(21000);
    checkOutput("tmo_err", errCount - errBase, 1);
    markCounts();
    applyStimulus(8'h69, 0, 0, 0);
    checkOutput("tmo_next_gd", gdCount - gdBase, 1);
    checkOutput("tmo_next_err", errCount - errBase, 0);
    checkOutput("tmo_next_cambio", {24'd0, Cambio}, 32'h69);

    markCounts();
    applyStimulus(8'h1C, 0, 0, 1);
    checkOutput("glitch_gd", gdCount - gdBase, 1);
    checkOutput("glitch_err", errCount - errBase, 0);
    checkOutput("glitch_cambio", {24'd0, Cambio}, 32'h1C);

    markCounts();
    sendBit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) sendBit(1'b1, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("midrst_cambio", {24'd0, Cambio}, 32'h00);
    checkOutput("midrst_gd", {31'd0, got_data}, 32'd0);
    checkOutput("midrst_ext", {31'd0, ext_key}, 32'd0);
    checkOutput("midrst_err", {31'd0, frame_err}, 32'd0);
    waitCycles(3);
    rst = 1'b1;
    waitCycles(10);
    applyStimulus(8'h69, 0, 0, 0);
    checkOutput("midrst_next_gd", gdCount - gdBase, 1);
    checkOutput("midrst_next_err", errCount - errBase, 0);
    checkOutput("midrst_next_cambio", {24'd0, Cambio}, 32'h69);

    checkOutput("gd_err_overlap", overlapCount, 0);
    checkOutput("gd_back_to_back", backToBack, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
